ccff_loader: RTL and testbench



---
 rtl/ccff_loader.sv | 171 +++++++++++++++++
 tb/tb_ccff_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_loader.sv
// ccff_loader: configuration-chain bitstream loader.
// Streams bytes MSB-first onto ccff_head with a generated prog_clk.
module ccff_loader #(
   parameter int CHAIN_LEN = 1024,
   parameter int DIV       = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [7:0]       din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             pReset,
   output logic             prog_clk,
   output logic             ccff_head,
   input  logic             ccff_tail,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] tail_ones
);

   typedef enum logic [2:0] {
      IDLE,
      PRESET,
      FETCH,
      SHIFT_LO,
      SHIFT_HI
   } state_t;

   localparam int DW = $clog2(2 * DIV) + 1;
   localparam logic [DW-1:0]    PRE_END  = DW'(2 * DIV - 1);
   localparam logic [DW-1:0]    PH_END   = DW'(DIV - 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] SAT      = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [DW-1:0]    div_q, div_d;
   logic [2:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       sreg_q, sreg_d;
   logic             rdy_q, rdy_d;
   logic             prst_q, prst_d;
   logic             pclk_q, pclk_d;
   logic             head_q, head_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] tail_q, tail_d;

   // State and registered outputs; reset drops every output at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         div_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         sreg_q  <= '0;
         rdy_q   <= 1'b0;
         prst_q  <= 1'b0;
         pclk_q  <= 1'b0;
         head_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         sreg_q  <= sreg_d;
         rdy_q   <= rdy_d;
         prst_q  <= prst_d;
         pclk_q  <= pclk_d;
         head_q  <= head_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         tail_q  <= tail_d;
      end
   end

   // Next state and next output values; head only moves as prog_clk falls.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      sreg_d  = sreg_q;
      rdy_d   = rdy_q;
      prst_d  = prst_q;
      pclk_d  = pclk_q;
      head_d  = head_q;
      busy_d  = busy_q;
      done_d  = done_q;
      tail_d  = tail_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = PRESET;
               div_d   = '0;
               cnt_d   = '0;
               tail_d  = '0;
               done_d  = 1'b0;
               busy_d  = 1'b1;
               prst_d  = 1'b1;
            end
         end
         PRESET: begin
            if (div_q == PRE_END) begin
               state_d = FETCH;
               div_d   = '0;
               prst_d  = 1'b0;
               rdy_d   = 1'b1;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         FETCH: begin
            if (din_valid && rdy_q) begin
               state_d = SHIFT_LO;
               div_d   = '0;
               sreg_d  = din;
               idx_d   = 3'd7;
               head_d  = din[7];
               rdy_d   = 1'b0;
            end
         end
         SHIFT_LO: begin
            if (div_q == PH_END) begin
               state_d = SHIFT_HI;
               div_d   = '0;
               pclk_d  = 1'b1;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         SHIFT_HI: begin
            if (div_q == '0 && ccff_tail && tail_q != SAT)
               tail_d = tail_q + 1'b1;
            if (div_q == PH_END) begin
               div_d  = '0;
               pclk_d = 1'b0;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == LAST_BIT) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else if (idx_q == 3'd0) begin
                  state_d = FETCH;
                  rdy_d   = 1'b1;
               end else begin
                  state_d = SHIFT_LO;
                  idx_d   = idx_q - 3'd1;
                  head_d  = sreg_q[idx_q - 3'd1];
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign din_ready = rdy_q;
   assign pReset    = prst_q;
   assign prog_clk  = pclk_q;
   assign ccff_head = head_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign tail_ones = tail_q;

endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: directed bench for the configuration-chain loader.
// Instance a: 8-bit chain, DIV=4. Instance b: 12-bit chain, DIV=2.
module tb_ccff_loader;

   localparam int DIV_A = 4;
   localparam int LEN_A = 8;
   localparam int DIV_B = 2;
   localparam int LEN_B = 12;
   localparam int CW    = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   logic          start_a = 0, din_valid_a = 0;
   logic [7:0]    din_a = '0;
   logic          din_ready_a, pReset_a, prog_clk_a, head_a;
   logic          busy_a, done_a;
   logic [CW-1:0] tail_a;

   logic          start_b = 0, din_valid_b = 0;
   logic [7:0]    din_b = '0;
   logic          din_ready_b, pReset_b, prog_clk_b, head_b;
   logic          busy_b, done_b;
   logic [CW-1:0] tail_b;

   always #5 clk = ~clk;

   ccff_loader #(.CHAIN_LEN(LEN_A), .DIV(DIV_A), .CNT_W(CW)) u_a (
      .clk(clk), .reset_n(reset_n), .start(start_a),
      .din(din_a), .din_valid(din_valid_a), .din_ready(din_ready_a),
      .pReset(pReset_a), .prog_clk(prog_clk_a), .ccff_head(head_a),
      .ccff_tail(head_a), .busy(busy_a), .done(done_a),
      .tail_ones(tail_a)
   );

   ccff_loader #(.CHAIN_LEN(LEN_B), .DIV(DIV_B), .CNT_W(CW)) u_b (
      .clk(clk), .reset_n(reset_n), .start(start_b),
      .din(din_b), .din_valid(din_valid_b), .din_ready(din_ready_b),
      .pReset(pReset_b), .prog_clk(prog_clk_b), .ccff_head(head_b),
      .ccff_tail(head_b), .busy(busy_b), .done(done_b),
      .tail_ones(tail_b)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // free-running cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   int          rises_a = 0, acc_a = 0, glitch_a = 0;
   int          acc_cyc_a = 0, done_cyc_a = 0;
   int          rlog_a[64];
   logic [31:0] bits_a = '0;
   logic        pc_prev_a = 0, hd_prev_a = 0, dn_prev_a = 0;

   int          rises_b = 0, acc_b = 0, glitch_b = 0;
   int          acc_cyc_b = 0, done_cyc_b = 0;
   int          rlog_b[64];
   logic [31:0] bits_b = '0;
   logic        pc_prev_b = 0, hd_prev_b = 0, dn_prev_b = 0;

   // instance a: log prog_clk rises, head at rise, handshakes, done edge
   always @(negedge clk) begin
      if (prog_clk_a && !pc_prev_a) begin
         rises_a <= rises_a + 1;
         rlog_a[rises_a % 64] <= cyc;
         bits_a <= {bits_a[30:0], head_a};
      end
      if (prog_clk_a && pc_prev_a && head_a != hd_prev_a)
         glitch_a <= glitch_a + 1;
      if (din_valid_a && din_ready_a) begin
         acc_a <= acc_a + 1;
         acc_cyc_a <= cyc;
      end
      if (done_a && !dn_prev_a) done_cyc_a <= cyc;
      pc_prev_a <= prog_clk_a;
      hd_prev_a <= head_a;
      dn_prev_a <= done_a;
   end

   // instance b: same observations
   always @(negedge clk) begin
      if (prog_clk_b && !pc_prev_b) begin
         rises_b <= rises_b + 1;
         rlog_b[rises_b % 64] <= cyc;
         bits_b <= {bits_b[30:0], head_b};
      end
      if (prog_clk_b && pc_prev_b && head_b != hd_prev_b)
         glitch_b <= glitch_b + 1;
      if (din_valid_b && din_ready_b) begin
         acc_b <= acc_b + 1;
         acc_cyc_b <= cyc;
      end
      if (done_b && !dn_prev_b) done_cyc_b <= cyc;
      pc_prev_b <= prog_clk_b;
      hd_prev_b <= head_b;
      dn_prev_b <= done_b;
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input bit b);
      tick();
      if (b) start_b = 1'b1;
      else start_a = 1'b1;
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic send(input bit b, input logic [7:0] v);
      int n = 0;
      if (b) din_b = v;
      else din_a = v;
      do begin
         @(negedge clk);
         n++;
      end while (!(b ? din_ready_b : din_ready_a) && n < 2000);
      if (n >= 2000) check("send_timeout", 0, 1);
      if (b) din_valid_b = 1'b1;
      else din_valid_a = 1'b1;
      @(posedge clk);
      #1;
      din_valid_a = 1'b0;
      din_valid_b = 1'b0;
   endtask

   task automatic wait_done(input bit b, input string tag);
      int n = 0;
      while (!(b ? done_b : done_a) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) check(tag, 0, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, abase, k, pr, fpr, lpr, frdy, viol, nb, n;
      logic hd0;

      // reset with random inputs
      repeat (6) begin
         @(negedge clk);
         start_a = 1'($urandom);
         din_a = 8'($urandom);
         din_valid_a = 1'($urandom);
         start_b = 1'($urandom);
         din_b = 8'($urandom);
         din_valid_b = 1'($urandom);
      end
      @(negedge clk);
      check("rst_out_a", {din_ready_a, pReset_a, prog_clk_a,
                          head_a, busy_a, done_a, tail_a}, 0);
      check("rst_out_b", {din_ready_b, pReset_b, prog_clk_b,
                          head_b, busy_b, done_b, tail_b}, 0);
      start_a = 0; din_valid_a = 0; start_b = 0; din_valid_b = 0;
      reset_n = 1'b1;
      tick();
      tick();
      @(negedge clk);
      check("idle_ready_a", din_ready_a, 0);
      check("idle_busy_a", busy_a, 0);

      // preset pulse and single byte on instance a
      base = rises_a;
      abase = acc_a;
      do_start(0);
      pr = 0; fpr = 0; lpr = 0; frdy = 0;
      for (k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) check("busy_t1", busy_a, 1);
         if (pReset_a) begin
            pr++;
            if (fpr == 0) fpr = k;
            lpr = k;
         end
         if (din_ready_a && frdy == 0) frdy = k;
      end
      check("preset_len", pr, 2 * DIV_A);
      check("preset_first", fpr, 1);
      check("preset_last", lpr, 2 * DIV_A);
      check("fetch_cycle", frdy, 2 * DIV_A + 1);
      send(0, 8'hA5);
      wait_done(0, "done_a_timeout");
      @(negedge clk);
      @(negedge clk);
      check("a_rises", rises_a - base, LEN_A);
      check("a_bits", bits_a[7:0], 8'hA5);
      check("a_tail", tail_a, 4);
      check("a_accepts", acc_a - abase, 1);
      check("a_done", done_a, 1);
      check("a_busy", busy_a, 0);
      check("a_first_rise", rlog_a[base % 64] - acc_cyc_a, DIV_A + 1);
      check("a_done_lat", done_cyc_a - rlog_a[(base + 7) % 64], DIV_A);
      check("a_glitch", glitch_a, 0);

      // partial last byte with a 50-cycle stall on instance b
      base = rises_b;
      abase = acc_b;
      do_start(1);
      send(1, 8'hFF);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!din_ready_b && n < 2000);
      if (n >= 2000) check("gap_timeout", 0, 1);
      hd0 = head_b;
      viol = 0;
      repeat (50) begin
         @(negedge clk);
         if (prog_clk_b || head_b !== hd0 || !din_ready_b) viol++;
      end
      check("gap_frozen", viol, 0);
      check("gap_rises", rises_b - base, 8);
      send(1, 8'h0F);
      wait_done(1, "done_b_timeout");
      @(negedge clk);
      @(negedge clk);
      check("b_rises", rises_b - base, LEN_B);
      check("b_bits", bits_b[11:0], 12'hFF0);
      check("b_tail", tail_b, 8);
      check("b_accepts", acc_b - abase, 2);
      check("b_done_lat", done_cyc_b - rlog_b[(base + 11) % 64], DIV_B);
      check("b_glitch", glitch_b, 0);

      // start during SHIFT_HI is ignored, then reset mid-byte
      do_start(1);
      send(1, 8'h3C);
      n = 0;
      while (!prog_clk_b && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) check("hi_timeout", 0, 1);
      start_b = 1'b1;
      @(posedge clk);
      #1;
      start_b = 1'b0;
      pr = 0;
      nb = 0;
      repeat (6) begin
         @(negedge clk);
         if (pReset_b) pr++;
         if (!busy_b || done_b) nb++;
      end
      check("ign_preset", pr, 0);
      check("ign_busy", nb, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_b", {din_ready_b, pReset_b, prog_clk_b,
                          head_b, busy_b, done_b, tail_b}, 0);
      check("mid_rst_a", {din_ready_a, pReset_a, prog_clk_a,
                          head_a, busy_a, done_a, tail_a}, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // clean reload after reset
      base = rises_b;
      do_start(1);
      send(1, 8'hA5);
      send(1, 8'h80);
      wait_done(1, "reload_timeout");
      @(negedge clk);
      @(negedge clk);
      check("re_rises", rises_b - base, LEN_B);
      check("re_bits", bits_b[11:0], 12'hA58);
      check("re_tail", tail_b, 5);
      check("re_done", done_b, 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
